// File: rtl/nx_xrfb_fifo_pkg.sv
// Shared geometry of the NX_XRFB_64x18 register file and the FIFO counters
// that sequence it, plus the occupancy update rule.
package nx_fifo_defs;

   localparam int NX_XRFB_DEPTH = 64;
   localparam int NX_XRFB_WIDTH = 18;
   localparam int NX_XRFB_AW    = 6;
   localparam int NX_FIFO_CW    = 7;

   typedef logic [NX_XRFB_AW-1:0]    nx_ptr_t;
   typedef logic [NX_FIFO_CW-1:0]    nx_cnt_t;
   typedef logic [NX_XRFB_WIDTH-1:0] nx_word_t;

   function automatic nx_cnt_t nx_cnt_next(input nx_cnt_t cnt, input logic wr, input logic rd);
      nx_cnt_t res;
      res = cnt;
      case ({wr, rd})
         2'b10:   res = cnt + nx_cnt_t'(1);
         2'b01:   res = cnt - nx_cnt_t'(1);
         default: res = cnt;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/nx_xrfb_fifo_xrfb.sv
// Behavioural NX_XRFB_64x18 register file: synchronous write, asynchronous read.
// Contents are never cleared.
module NX_XRFB_64x18
   import nx_fifo_defs::*;
#(
   parameter bit wck_edge = 1'b0
) (
   input  logic       CK,
   input  logic       WE,
   input  logic       WEA,
   input  logic [5:0] WA,
   input  logic [17:0] I,
   input  logic [5:0] RA,
   output logic [17:0] O
);

   nx_word_t mem [0:NX_XRFB_DEPTH-1];

   generate
      if (wck_edge == 1'b0) begin : g_wr_pos
         always_ff @(posedge CK) begin
            if (WE & WEA) mem[WA] <= I;
         end
      end else begin : g_wr_neg
         always_ff @(negedge CK) begin
            if (WE & WEA) mem[WA] <= I;
         end
      end
   endgenerate

   assign O = mem[RA];

endmodule

// File: rtl/nx_xrfb_fifo.sv
// 64x18 synchronous FIFO controller around one NX_XRFB_64x18: pointers,
// occupancy, registered status flags and a one-cycle registered read port.
module nx_xrfb_fifo
   import nx_fifo_defs::*;
#(
   parameter int AF_LEVEL = 48,
   parameter int AE_LEVEL = 8
) (
   input  logic        CK,
   input  logic        R,
   input  logic [17:0] I,
   input  logic        WE,
   output logic        FULL,
   output logic        AFULL,
   input  logic        RE,
   output logic [17:0] O,
   output logic        OV,
   output logic        EMPTY,
   output logic        AEMPTY,
   output logic [6:0]  CNT,
   output logic        OVF,
   output logic        UDF
);

   nx_ptr_t  wr_ptr, rd_ptr;
   nx_cnt_t  cnt_q, cnt_nxt;
   nx_word_t mem_o, o_p1;
   logic     vld_p1;
   logic     full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
   logic     wr_acc, rd_acc, mem_we;

   assign wr_acc  = WE & ~full_q;
   assign rd_acc  = RE & ~empty_q;
   assign cnt_nxt = nx_cnt_next(cnt_q, wr_acc, rd_acc);
   // Reset must keep the write out of the register file in the same cycle.
   assign mem_we  = wr_acc & ~R;

   // RA is driven straight from rd_ptr: RA->O is the slow path.
   NX_XRFB_64x18 #(
      .wck_edge (1'b0)
   ) u_mem (
      .CK  (CK),
      .WE  (mem_we),
      .WEA (mem_we),
      .WA  (wr_ptr),
      .I   (I),
      .RA  (rd_ptr),
      .O   (mem_o)
   );

   // ---- stage p1: state, flags and registered read data ----
   always_ff @(posedge CK) begin
      if (R) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= (AF_LEVEL == 0);
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         vld_p1   <= 1'b0;
         o_p1     <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + nx_ptr_t'(1);
         if (rd_acc) begin
            rd_ptr <= rd_ptr + nx_ptr_t'(1);
            o_p1   <= mem_o;
         end
         vld_p1   <= rd_acc;
         cnt_q    <= cnt_nxt;
         full_q   <= (int'(cnt_nxt) == NX_XRFB_DEPTH);
         empty_q  <= (cnt_nxt == '0);
         afull_q  <= (int'(cnt_nxt) >= AF_LEVEL);
         aempty_q <= (int'(cnt_nxt) <= AE_LEVEL);
         ovf_q    <= ovf_q | (WE & full_q);
         udf_q    <= udf_q | (RE & empty_q);
      end
   end

   assign CNT    = cnt_q;
   assign FULL   = full_q;
   assign EMPTY  = empty_q;
   assign AFULL  = afull_q;
   assign AEMPTY = aempty_q;
   assign OVF    = ovf_q;
   assign UDF    = udf_q;
   assign O      = o_p1;
   assign OV     = vld_p1;

endmodule

// File: tb/tb_nx_xrfb_fifo.sv
// Directed bench for nx_xrfb_fifo: a queue-based reference checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_nx_xrfb_fifo;

   localparam int AF = 48;
   localparam int AE = 8;

   logic        CK = 1'b0;
   logic        R = 1'b1;
   logic [17:0] I = '0;
   logic        WE = 1'b0;
   logic        RE = 1'b0;
   logic        FULL, AFULL, OV, EMPTY, AEMPTY, OVF, UDF;
   logic [17:0] O;
   logic [6:0]  CNT;

   int checks = 0;
   int errors = 0;

   nx_xrfb_fifo #(.AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .CK(CK), .R(R), .I(I), .WE(WE), .FULL(FULL), .AFULL(AFULL),
      .RE(RE), .O(O), .OV(OV), .EMPTY(EMPTY), .AEMPTY(AEMPTY),
      .CNT(CNT), .OVF(OVF), .UDF(UDF)
   );

   always #5 CK = ~CK;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: a plain queue of words plus sticky bits.
   logic [17:0] q[$];
   logic [17:0] m_o = '0;
   bit          m_ov = 0, m_ovf = 0, m_udf = 0, m_ok = 0;

   always @(posedge CK) begin
      if (R) begin
         q.delete();
         m_o = '0; m_ov = 0; m_ovf = 0; m_udf = 0; m_ok = 1;
      end else begin
         bit w, r;
         w = WE && (q.size() < 64);
         r = RE && (q.size() > 0);
         if (WE && q.size() == 64) m_ovf = 1;
         if (RE && q.size() == 0)  m_udf = 1;
         m_ov = r;
         if (r) m_o = q.pop_front();
         if (w) q.push_back(I);
      end
   end

   always @(negedge CK) begin
      if (m_ok) begin
         chk("cnt", int'(CNT), q.size());
         chk("full", int'(FULL), int'(q.size() == 64));
         chk("empty", int'(EMPTY), int'(q.size() == 0));
         chk("afull", int'(AFULL), int'(q.size() >= AF));
         chk("aempty", int'(AEMPTY), int'(q.size() <= AE));
         chk("ov", int'(OV), int'(m_ov));
         chk("o", int'(O), int'(m_o));
         chk("ovf", int'(OVF), int'(m_ovf));
         chk("udf", int'(UDF), int'(m_udf));
      end
      if (R) chk("mem_we_in_reset", int'(dut.u_mem.WE), 0);
   end

   // Inputs change 2 time units after the edge that consumed the previous ones.
   task automatic step(input logic we, input logic re, input logic [17:0] d);
      WE = we; RE = re; I = d;
      @(posedge CK);
      #2;
   endtask

   initial begin
      R = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      R = 1'b0;
      step(0, 0, 0);
      chk("lit_rst_cnt", int'(CNT), 0);
      chk("lit_rst_empty", int'(EMPTY), 1);
      chk("lit_rst_full", int'(FULL), 0);
      chk("lit_rst_aempty", int'(AEMPTY), 1);
      chk("lit_rst_afull", int'(AFULL), 0);
      chk("lit_rst_o", int'(O), 0);
      chk("lit_rst_ovf", int'(OVF), 0);

      // read while empty
      step(0, 1, 0);
      chk("lit_udf", int'(UDF), 1);
      chk("lit_udf_ov", int'(OV), 0);
      chk("lit_udf_cnt", int'(CNT), 0);

      // three words through
      for (int k = 1; k <= 3; k++) step(1, 0, 18'(k));
      chk("lit_cnt3", int'(CNT), 3);
      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0);
         chk("lit_rd_o", int'(O), k);
         chk("lit_rd_ov", int'(OV), 1);
      end
      step(0, 0, 0);
      chk("lit_drained_empty", int'(EMPTY), 1);
      chk("lit_drained_ov", int'(OV), 0);

      // fill to full
      for (int k = 0; k < 64; k++) begin
         step(1, 0, 18'(k));
         if (k == 46) chk("lit_afull_47", int'(AFULL), 0);
         if (k == 47) chk("lit_afull_48", int'(AFULL), 1);
      end
      chk("lit_full", int'(FULL), 1);
      chk("lit_full_cnt", int'(CNT), 64);
      step(1, 0, 18'h3ffff);
      chk("lit_ovf", int'(OVF), 1);
      chk("lit_ovf_cnt", int'(CNT), 64);
      for (int k = 0; k < 64; k++) begin
         step(0, 1, 0);
         chk("lit_drain_o", int'(O), k);
      end
      chk("lit_drain_empty", int'(EMPTY), 1);

      // full with both requests
      for (int k = 0; k < 64; k++) step(1, 0, 18'(k + 100));
      step(1, 1, 18'd555);
      chk("lit_fb_o", int'(O), 100);
      chk("lit_fb_cnt", int'(CNT), 63);
      chk("lit_fb_full", int'(FULL), 0);
      for (int k = 0; k < 63; k++) step(0, 1, 0);
      chk("lit_fb_last", int'(O), 163);

      // steady state at occupancy 5, pointers wrap several times
      for (int k = 0; k < 5; k++) step(1, 0, 18'(1000 + k));
      for (int k = 0; k < 200; k++) step(1, 1, 18'(2000 + k));
      chk("lit_ss_cnt", int'(CNT), 5);
      chk("lit_ss_o", int'(O), 2194);

      // reset mid-stream at occupancy 20
      for (int k = 0; k < 15; k++) step(1, 0, 18'(3000 + k));
      chk("lit_pre_rst_cnt", int'(CNT), 20);
      R = 1'b1;
      step(1, 1, 18'h2aaaa);
      R = 1'b0;
      chk("lit_mid_rst_cnt", int'(CNT), 0);
      chk("lit_mid_rst_empty", int'(EMPTY), 1);
      chk("lit_mid_rst_ov", int'(OV), 0);
      chk("lit_mid_rst_o", int'(O), 0);
      step(1, 0, 18'd7);
      step(0, 1, 0);
      chk("lit_post_rst_o", int'(O), 7);
      step(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
